ccff_chain_loader: RTL and testbench

- Configuration-chain programmer for one logic-block tile (LUT4 truth table plus output-mux select bits, daisy-chained through ccff_head/ccff_tail).
- Accepts bitstream words over a valid/ready stream and serialises them one bit per cycle onto the chain, gating the chain's shift enable.
- Optionally runs a non-destructive verify pass: the chain is recirculated tail-to-head for CHAIN_LEN cycles and each bit is compared against a shadow copy.
- Sits between the bitstream fetch logic and the tile's ccff_head/ccff_tail pins.

---
 rtl/ccff_chain_loader_pkg.sv | 30 +++
 rtl/ccff_word_serializer.sv | 48 ++++
 rtl/ccff_chain_loader.sv | 130 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
//   state_t        : loader FSM states
//   num_words()    : words needed to cover a chain of a given length
//   cnt_w()        : counter width able to hold 0..max
// The localparams below describe the default tile (LUT4 + 2 mux bits).
package ccff_chain_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_VERIFY,
    ST_DONE
  } state_t;

  function automatic int num_words(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int CHAIN_LEN_DEF = 18;
  localparam int WORD_W_DEF    = 8;
  localparam int NUM_WORDS     = num_words(CHAIN_LEN_DEF, WORD_W_DEF);
  localparam int BIT_CNT_W     = cnt_w(CHAIN_LEN_DEF);
  localparam int WORD_CNT_W    = cnt_w(NUM_WORDS);

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer for the configuration chain.
//   load      : capture data into the shift register, restart bit count
//   shift     : emit bit_out this cycle and advance by one bit
//   last      : current word is the final one (only LAST_LEN bits used)
//   bit_out   : LSB of the word register
//   word_done : this shift cycle emits the final bit of the word
module ccff_word_serializer
  import ccff_chain_loader_pkg::*;
#(
  parameter int WORD_W   = 8,
  parameter int LAST_LEN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic              last,
  input  logic [WORD_W-1:0] data,
  output logic              bit_out,
  output logic              word_done
);

  localparam int CW = cnt_w(WORD_W);
  localparam logic [CW-1:0] FULL_END = CW'(WORD_W - 1);
  localparam logic [CW-1:0] LAST_END = CW'(LAST_LEN - 1);

  logic [WORD_W-1:0] word_reg;
  logic [CW-1:0]     wbit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_reg <= '0;
      wbit     <= '0;
    end else if (load) begin
      word_reg <= data;
      wbit     <= '0;
    end else if (shift) begin
      word_reg <= word_reg >> 1;
      wbit     <= wbit + 1'b1;
    end
  end

  assign bit_out = word_reg[0];

  // Upper bits of the final word never reach the chain.
  assign word_done = shift && (wbit == (last ? LAST_END : FULL_END));

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain programmer for one logic-block tile.
//   prog_clk/reset      : clock, async active-low reset
//   start/verify_en     : begin load (verify_en sampled with start)
//   abort               : return to IDLE from any state
//   s_valid/s_ready/s_data : bitstream word stream, bit 0 shifted first
//   ccff_head/ccff_tail : chain serial in / serial out
//   shift_en            : chain clock-enable
//   busy/done/error     : status; error is a sticky verify mismatch
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int NWORDS   = num_words(CHAIN_LEN, WORD_W);
  localparam int BCW      = cnt_w(CHAIN_LEN);
  localparam int WCW      = cnt_w(NWORDS);
  localparam int LAST_LEN = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam logic [BCW-1:0] BIT_END  = BCW'(CHAIN_LEN - 1);
  localparam logic [WCW-1:0] WORD_END = WCW'(NWORDS - 1);

  state_t               state, next;
  logic [BCW-1:0]       bit_cnt;
  logic [WCW-1:0]       word_idx;
  logic [CHAIN_LEN-1:0] shadow;
  logic                 verify_lat;
  logic                 ser_shift, ser_bit, word_done, handshake, accept_start;

  assign ser_shift    = (state == ST_SHIFT) && !abort;
  assign handshake    = s_valid && s_ready;
  assign accept_start = start && !abort && (state == ST_IDLE || state == ST_DONE);

  ccff_word_serializer #(
    .WORD_W   (WORD_W),
    .LAST_LEN (LAST_LEN)
  ) u_ser (
    .clk       (prog_clk),
    .reset     (reset),
    .load      (handshake),
    .shift     (ser_shift),
    .last      (word_idx == WORD_END),
    .data      (s_data),
    .bit_out   (ser_bit),
    .word_done (word_done)
  );

  always_comb begin
    next      = state;
    s_ready   = 1'b0;
    shift_en  = 1'b0;
    ccff_head = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) next = ST_LOAD;
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) next = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en  = 1'b1;
        ccff_head = ser_bit;
        if (word_done)
          next = (bit_cnt != BIT_END) ? ST_LOAD : (verify_lat ? ST_VERIFY : ST_DONE);
      end
      ST_VERIFY: begin
        shift_en  = 1'b1;
        ccff_head = ccff_tail;
        if (bit_cnt == BIT_END) next = ST_DONE;
      end
      default: next = ST_IDLE;
    endcase
    // Gated here so the aborting edge neither shifts the chain nor accepts a word.
    if (abort) begin
      next     = ST_IDLE;
      s_ready  = 1'b0;
      shift_en = 1'b0;
    end
  end

  assign busy = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_VERIFY);
  assign done = (state == ST_DONE);

  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      word_idx   <= '0;
      shadow     <= '0;
      verify_lat <= 1'b0;
      error      <= 1'b0;
    end else begin
      state <= next;
      if (accept_start) begin
        verify_lat <= verify_en;
        error      <= 1'b0;
        bit_cnt    <= '0;
        word_idx   <= '0;
      end
      if (handshake) begin
        for (int unsigned j = 0; j < CHAIN_LEN; j++)
          if (j / WORD_W == 32'(word_idx)) shadow[j] <= s_data[j % WORD_W];
      end
      if (state == ST_SHIFT && shift_en) begin
        // bit_cnt restarts at 0 so VERIFY can use it as the shadow index.
        bit_cnt <= (word_done && bit_cnt == BIT_END) ? '0 : bit_cnt + 1'b1;
        if (word_done && word_idx != WORD_END) word_idx <= word_idx + 1'b1;
      end
      if (state == ST_VERIFY && shift_en) begin
        if (ccff_tail != shadow[bit_cnt]) error <= 1'b1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  logic       prog_clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, verify_en = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, ccff_head, ccff_tail, shift_en, busy, done, error;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected chain image: bit j is the j-th bit shifted out.
  localparam logic [17:0] PATTERN = 18'h23CA5;
  logic [7:0] words [3] = '{8'hA5, 8'h3C, 8'h02};

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader dut (
    .prog_clk  (prog_clk),
    .reset     (reset),
    .start     (start),
    .verify_en (verify_en),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // 18-flop chain: head enters at [17], tail is [0]; after a full load
  // flop j holds the j-th shifted bit. Optional stuck-at-0 on flop 5.
  logic [17:0] chain = '0;
  logic        stuck = 1'b0;
  assign ccff_tail = chain[0];
  always @(posedge prog_clk) begin
    if (shift_en) begin
      chain <= {ccff_head, chain[17:1]};
      if (stuck) chain[5] <= 1'b0;
    end
  end

  // Starts a run and feeds words; lat = edges from the start edge to the
  // observed state. Stops at done, at lat==stop_at, or after 200 cycles.
  task automatic do_run(input logic v, input int gap, input int stop_at,
                        output int lat, output int nshift,
                        output logic [17:0] hseq, output logic timed_out);
    int widx = 0, gap_cnt = 0;
    logic ended = 1'b0;
    nshift = 0; hseq = '0; lat = 0;
    @(negedge prog_clk);
    start = 1'b1; verify_en = v; s_valid = 1'b0;
    @(posedge prog_clk);
    #1 start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge prog_clk);
      if (shift_en) begin
        if (nshift < 18) hseq[nshift] = ccff_head;
        nshift++;
      end
      if (done || (stop_at >= 0 && lat == stop_at)) begin
        ended = 1'b1;
        break;
      end
      if (s_ready) begin
        s_data = (widx < 3) ? words[widx] : 8'h00;
        if (gap_cnt < gap) begin
          s_valid = 1'b0; gap_cnt++;
        end else begin
          s_valid = 1'b1; gap_cnt = 0; widx++;
        end
      end else s_valid = 1'b0;
      lat++;
    end
    s_valid = 1'b0;
    timed_out = !ended;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({s_ready, shift_en, ccff_head, busy, done, error} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 000000",
               {s_ready, shift_en, ccff_head, busy, done, error});
    end
    @(negedge prog_clk); reset = 1'b1;
    @(negedge prog_clk);
    n_cmp++;
    if ({busy, done, s_ready} !== 3'b0) begin
      n_bad++; $display("FAIL idle_after_reset: busy/done/ready=%b want 000", {busy, done, s_ready});
    end
  endtask

  task automatic test_load();
    int lat, ns; logic [17:0] hs; logic to;
    do_run(1'b0, 0, -1, lat, ns, hs, to);
    n_cmp++; if (to)      begin n_bad++; $display("FAIL load_timeout: done never seen"); end
    n_cmp++; if (ns != 18) begin n_bad++; $display("FAIL load_shift_cnt: got %0d want 18", ns); end
    n_cmp++; if (hs !== PATTERN) begin n_bad++; $display("FAIL load_head_seq: got %h want %h", hs, PATTERN); end
    n_cmp++; if (lat != 21) begin n_bad++; $display("FAIL load_latency: got %0d want 21", lat); end
    n_cmp++; if (chain !== PATTERN) begin n_bad++; $display("FAIL load_chain: got %h want %h", chain, PATTERN); end
    n_cmp++; if ({done, busy, error} !== 3'b100) begin n_bad++; $display("FAIL load_status: done/busy/err=%b want 100", {done, busy, error}); end
  endtask

  task automatic test_verify_ok();
    int lat, ns; logic [17:0] hs; logic to;
    do_run(1'b1, 0, -1, lat, ns, hs, to);
    n_cmp++; if (to)      begin n_bad++; $display("FAIL verify_timeout: done never seen"); end
    n_cmp++; if (ns != 36) begin n_bad++; $display("FAIL verify_shift_cnt: got %0d want 36", ns); end
    n_cmp++; if (lat != 39) begin n_bad++; $display("FAIL verify_latency: got %0d want 39", lat); end
    n_cmp++; if ({done, error} !== 2'b10) begin n_bad++; $display("FAIL verify_status: done/err=%b want 10", {done, error}); end
    n_cmp++; if (chain !== PATTERN) begin n_bad++; $display("FAIL verify_chain_kept: got %h want %h", chain, PATTERN); end
  endtask

  task automatic test_verify_stuck();
    int lat, ns; logic [17:0] hs; logic to;
    stuck = 1'b1;
    do_run(1'b1, 0, -1, lat, ns, hs, to);
    stuck = 1'b0;
    n_cmp++; if (to) begin n_bad++; $display("FAIL stuck_timeout: done never seen"); end
    n_cmp++; if ({done, error} !== 2'b11) begin n_bad++; $display("FAIL stuck_error: done/err=%b want 11", {done, error}); end
    repeat (3) @(negedge prog_clk);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL stuck_sticky: err=%b want 1", error); end
    do_run(1'b0, 0, 0, lat, ns, hs, to);
    n_cmp++; if ({busy, error} !== 2'b10) begin n_bad++; $display("FAIL error_clear_on_start: busy/err=%b want 10", {busy, error}); end
    abort = 1'b1; @(posedge prog_clk); #1 abort = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat, ns; logic [17:0] hs; logic to;
    do_run(1'b0, 4, -1, lat, ns, hs, to);
    n_cmp++; if (to)       begin n_bad++; $display("FAIL bp_timeout: done never seen"); end
    n_cmp++; if (ns != 18) begin n_bad++; $display("FAIL bp_shift_cnt: got %0d want 18", ns); end
    n_cmp++; if (hs !== PATTERN) begin n_bad++; $display("FAIL bp_head_seq: got %h want %h", hs, PATTERN); end
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL bp_latency: got %0d want 33", lat); end
  endtask

  task automatic test_abort();
    int lat, ns; logic [17:0] hs; logic to;
    // lat 12 = third SHIFT cycle of word 1 (bits 8,9,10 shifted)
    do_run(1'b0, 0, 12, lat, ns, hs, to);
    n_cmp++; if (ns != 11) begin n_bad++; $display("FAIL abort_point: shifts=%0d want 11", ns); end
    abort = 1'b1;
    @(posedge prog_clk); #1 abort = 1'b0;
    n_cmp++;
    if ({busy, shift_en, done, s_ready} !== 4'b0) begin
      n_bad++; $display("FAIL abort_idle: busy/sh/done/rdy=%b want 0000", {busy, shift_en, done, s_ready});
    end
    do_run(1'b0, 0, -1, lat, ns, hs, to);
    n_cmp++; if (to || lat != 21) begin n_bad++; $display("FAIL abort_reload_lat: got %0d want 21", lat); end
    n_cmp++; if (chain !== PATTERN) begin n_bad++; $display("FAIL abort_reload_chain: got %h want %h", chain, PATTERN); end
  endtask

  task automatic test_reset_mid_verify();
    int lat, ns; logic [17:0] hs; logic to;
    stuck = 1'b1;
    do_run(1'b1, 0, 25, lat, ns, hs, to);
    n_cmp++;
    if ({busy, shift_en, error} !== 3'b111) begin
      n_bad++; $display("FAIL pre_reset_verify: busy/sh/err=%b want 111", {busy, shift_en, error});
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({s_ready, shift_en, ccff_head, busy, done, error} !== 6'b0) begin
      n_bad++; $display("FAIL async_reset: got %b want 000000",
                        {s_ready, shift_en, ccff_head, busy, done, error});
    end
    stuck = 1'b0;
    @(negedge prog_clk); reset = 1'b1;
    do_run(1'b0, 0, -1, lat, ns, hs, to);
    n_cmp++; if (to || lat != 21) begin n_bad++; $display("FAIL post_reset_lat: got %0d want 21", lat); end
    n_cmp++; if (hs !== PATTERN || chain !== PATTERN) begin
      n_bad++; $display("FAIL post_reset_load: head %h chain %h want %h", hs, chain, PATTERN);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_verify_ok();
    test_verify_stuck();
    test_backpressure();
    test_abort();
    test_reset_mid_verify();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
